mem_bus_arbiter: RTL and testbench

- Shares one downstream memory port between instruction fetch (port I) and the memory stage (port D).
- Per-port contract matches the pipeline's bus convention: the requester holds valid plus payload until data_ok; the stage stalls while valid && !data_ok.
- Allows one outstanding transaction at a time.
- Uses round-robin arbitration, latches the request, routes the response only to the owner, and includes a watchdog.

---
 rtl/mem_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between fetch (I) and memory stage (D).
// One transaction in flight; payload latched at grant, response routed to the owner, watchdog-guarded.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_data_ok,
  output logic [31:0]         iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                mreq_valid,
  output logic [ADDR_W-1:0]   mreq_addr,
  output logic [2:0]          mreq_size,
  output logic [DATA_W/8-1:0] mreq_strobe,
  output logic [DATA_W-1:0]   mreq_data,
  input  logic                mresp_ok,
  input  logic [DATA_W-1:0]   mresp_data,
  output logic                timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         size_q;
  logic [STRB_W-1:0]  strobe_q;
  logic [DATA_W-1:0]  data_q;
  logic               last_d_q;
  logic               mreq_valid_q;
  logic               timeout_err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic busy, grant_i, grant_d, wd_fire, done;

  always_comb begin
    busy    = (state_q != IDLE);
    grant_i = ireq_valid && (!dreq_valid || last_d_q);
    grant_d = dreq_valid && !grant_i;
    // Watchdog fires in the TIMEOUT-th busy cycle; a real response in that cycle wins.
    wd_fire = (TIMEOUT > 0) && busy && (cnt_q == CNT_LAST) && !mresp_ok;
    done    = busy && (mresp_ok || wd_fire);

    iresp_data_ok = done && (state_q == BUSY_I) && ireq_valid;
    dresp_data_ok = done && (state_q == BUSY_D) && dreq_valid;
    iresp_data    = '0;
    dresp_data    = '0;
    if (iresp_data_ok && mresp_ok)
      iresp_data = addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
    if (dresp_data_ok && mresp_ok)
      dresp_data = mresp_data;
  end

  assign mreq_valid  = mreq_valid_q;
  assign mreq_addr   = addr_q;
  assign mreq_size   = size_q;
  assign mreq_strobe = strobe_q;
  assign mreq_data   = data_q;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      size_q        <= '0;
      strobe_q      <= '0;
      data_q        <= '0;
      last_d_q      <= 1'b1;
      mreq_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q      <= BUSY_I;
            addr_q       <= ireq_addr;
            size_q       <= 3'd2;
            strobe_q     <= '0;
            data_q       <= '0;
            last_d_q     <= 1'b0;
            cnt_q        <= '0;
            mreq_valid_q <= 1'b1;
          end else if (grant_d) begin
            state_q      <= BUSY_D;
            addr_q       <= dreq_addr;
            size_q       <= dreq_size;
            strobe_q     <= dreq_strobe;
            data_q       <= dreq_data;
            last_d_q     <= 1'b1;
            cnt_q        <= '0;
            mreq_valid_q <= 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (done) begin
            state_q      <= IDLE;
            mreq_valid_q <= 1'b0;
            if (wd_fire) timeout_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ok;
  logic [63:0] mresp_data;
  logic        timeout_err;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_ok(mresp_ok), .mresp_data(mresp_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic iv; logic [63:0] ia;
    logic dv; logic [63:0] da; logic [2:0] dsz; logic [7:0] dstb; logic [63:0] dd;
    logic mok; logic [63:0] md;
    logic e_mv; logic [63:0] e_ma; logic [2:0] e_ms; logic [7:0] e_mst; logic [63:0] e_md;
    logic e_iok; logic [31:0] e_id; logic e_dok; logic [63:0] e_dd;
  } vec_t;

  localparam logic [63:0] AF = 64'h8000_0004;
  localparam logic [63:0] AS = 64'h8000_0010;
  localparam logic [63:0] SD = 64'hDEAD_BEEF_0000_0001;

  vec_t tbl [14];

  typedef struct {
    bit is_d; logic [63:0] addr; logic [2:0] size; logic [7:0] stb; logic [63:0] data; int age;
  } txn_t;

  txn_t pend[$];
  txn_t lat;
  txn_t t;
  bit   last_d;
  bit   m_err;

  task automatic drive_idle();
    ireq_valid = 0; ireq_addr = '0; dreq_valid = 0; dreq_addr = '0; dreq_size = '0;
    dreq_strobe = '0; dreq_data = '0; mresp_ok = 0; mresp_data = '0;
  endtask

  initial begin
    logic e_mv, e_iok, e_dok, done, to, pick_d;
    logic [31:0] e_id;
    logic [63:0] e_dd;

    // single fetch, tie after a fetch (D wins), store with mid-busy data change, stray response
    tbl[0]  = '{1, AF, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0,       0, 0, 0, 0};
    tbl[1]  = '{1, AF, 0, 0, 0, 0, 0, 0, 0,                     1, AF, 2, 0, 0,      0, 0, 0, 0};
    tbl[2]  = '{1, AF, 0, 0, 0, 0, 0, 0, 0,                     1, AF, 2, 0, 0,      0, 0, 0, 0};
    tbl[3]  = '{1, AF, 0, 0, 0, 0, 0, 0, 0,                     1, AF, 2, 0, 0,      0, 0, 0, 0};
    tbl[4]  = '{1, AF, 0, 0, 0, 0, 0, 1, 64'h1111_2222_3333_4444, 1, AF, 2, 0, 0,    1, 32'h1111_2222, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                      0, AF, 2, 0, 0,      0, 0, 0, 0};
    tbl[6]  = '{1, 64'h1000, 1, 64'h2000, 3, 0, 0, 0, 0,        0, AF, 2, 0, 0,      0, 0, 0, 0};
    tbl[7]  = '{1, 64'h1000, 1, 64'h2000, 3, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD,
                1, 64'h2000, 3, 0, 0,  0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD};
    tbl[8]  = '{1, 64'h1000, 0, 0, 0, 0, 0, 0, 0,               0, 64'h2000, 3, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 64'h1000, 0, 0, 0, 0, 0, 1, 64'h5555_6666_7777_8888,
                1, 64'h1000, 2, 0, 0,  1, 32'h7777_8888, 0, 0};
    tbl[10] = '{0, 0, 1, AS, 3, 8'hFF, SD, 0, 0,                0, 64'h1000, 2, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, AS, 3, 8'hFF, 64'h0123, 0, 0,          1, AS, 3, 8'hFF, SD, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 1, AS, 3, 8'hFF, 64'h0456, 1, 64'hABCD,   1, AS, 3, 8'hFF, SD, 0, 0, 1, 64'hABCD};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 64'h77,                 0, AS, 3, 8'hFF, SD, 0, 0, 0, 0};

    drive_idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mv", mreq_valid, 0);   chk("rst_maddr", mreq_addr, 0);
    chk("rst_iok", iresp_data_ok, 0); chk("rst_dok", dresp_data_ok, 0);
    chk("rst_err", timeout_err, 0); chk("rst_mdata", mreq_data, 0);
    resetn = 1;

    for (int k = 0; k < 14; k++) begin
      ireq_valid = tbl[k].iv; ireq_addr = tbl[k].ia;
      dreq_valid = tbl[k].dv; dreq_addr = tbl[k].da; dreq_size = tbl[k].dsz;
      dreq_strobe = tbl[k].dstb; dreq_data = tbl[k].dd;
      mresp_ok = tbl[k].mok; mresp_data = tbl[k].md;
      #1;
      chk($sformatf("r%0d_mv", k), mreq_valid, tbl[k].e_mv);
      chk($sformatf("r%0d_maddr", k), mreq_addr, tbl[k].e_ma);
      chk($sformatf("r%0d_msize", k), mreq_size, tbl[k].e_ms);
      chk($sformatf("r%0d_mstb", k), mreq_strobe, tbl[k].e_mst);
      chk($sformatf("r%0d_mdata", k), mreq_data, tbl[k].e_md);
      chk($sformatf("r%0d_iok", k), iresp_data_ok, tbl[k].e_iok);
      chk($sformatf("r%0d_idata", k), iresp_data, tbl[k].e_id);
      chk($sformatf("r%0d_dok", k), dresp_data_ok, tbl[k].e_dok);
      chk($sformatf("r%0d_ddata", k), dresp_data, tbl[k].e_dd);
      chk($sformatf("r%0d_err", k), timeout_err, 0);
      tick();
    end

    // ties after reset alternate I, D, I, D; re-grant lands two cycles after data_ok
    drive_idle();
    resetn = 0;
    tick();
    resetn = 1;
    for (int k = 0; k < 4; k++) begin
      bit exp_d;
      exp_d = (k % 2) == 1;
      ireq_valid = 1; ireq_addr = 64'h100; dreq_valid = 1; dreq_addr = 64'h200; mresp_ok = 0;
      #1;
      chk("tie_idle_mv", mreq_valid, 0);
      tick();
      chk("tie_busy_mv", mreq_valid, 1);
      chk("tie_owner", mreq_addr, exp_d ? 64'h200 : 64'h100);
      mresp_ok = 1; mresp_data = 64'hC0DE_0000_0000_0000 | 64'(k);
      #1;
      chk("tie_iok", iresp_data_ok, !exp_d);
      chk("tie_dok", dresp_data_ok, exp_d);
      tick();
      mresp_ok = 0;
    end

    // flush: D drops valid mid-transaction; pending I is served next
    ireq_valid = 0; dreq_valid = 1; dreq_addr = 64'h3000; dreq_strobe = 0;
    #1; chk("fl_idle", mreq_valid, 0);
    tick();
    ireq_valid = 1; ireq_addr = 64'h4000;
    #1; chk("fl_mv1", mreq_valid, 1); chk("fl_addr", mreq_addr, 64'h3000);
    tick();
    dreq_valid = 0;
    #1; chk("fl_mv2", mreq_valid, 1); chk("fl_dok2", dresp_data_ok, 0);
    tick();
    mresp_ok = 1; mresp_data = 64'h99;
    #1; chk("fl_mv3", mreq_valid, 1); chk("fl_dok3", dresp_data_ok, 0); chk("fl_iok3", iresp_data_ok, 0);
    tick();
    mresp_ok = 0;
    #1; chk("fl_back_idle", mreq_valid, 0);
    tick();
    #1; chk("fl_i_mv", mreq_valid, 1); chk("fl_i_addr", mreq_addr, 64'h4000); chk("fl_i_size", mreq_size, 2);
    mresp_ok = 1; mresp_data = 64'h0000_0001_0000_0002;
    #1; chk("fl_i_ok", iresp_data_ok, 1); chk("fl_i_data", iresp_data, 32'h2);
    tick();
    mresp_ok = 0; ireq_valid = 0;

    // watchdog: no response for TMO busy cycles
    dreq_valid = 1; dreq_addr = 64'h5000;
    #1; chk("wd_idle", mreq_valid, 0);
    tick();
    for (int b = 1; b <= TMO; b++) begin
      mresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk("wd_mv", mreq_valid, 1);
      chk("wd_dok", dresp_data_ok, b == TMO);
      chk("wd_err_pre", timeout_err, 0);
      if (b == TMO) chk("wd_data0", dresp_data, 0);
      tick();
    end
    dreq_valid = 0; mresp_ok = 1;
    #1; chk("wd_mv_drop", mreq_valid, 0); chk("wd_stray_dok", dresp_data_ok, 0);
    chk("wd_stray_iok", iresp_data_ok, 0); chk("wd_err", timeout_err, 1);
    tick();
    mresp_ok = 0;
    tick();
    chk("wd_err_sticky", timeout_err, 1);

    // async reset in the middle of an I transaction, then a tie must go to I
    ireq_valid = 1; ireq_addr = 64'h6000;
    tick();
    dreq_valid = 1; dreq_addr = 64'h7000; mresp_ok = 1; mresp_data = 64'h1234;
    #1; chk("ar_pre_iok", iresp_data_ok, 1);
    #1; resetn = 0;
    #1; chk("ar_mv", mreq_valid, 0); chk("ar_iok", iresp_data_ok, 0); chk("ar_err", timeout_err, 0);
    mresp_ok = 0;
    tick();
    resetn = 1;
    #1; chk("ar_idle", mreq_valid, 0);
    tick();
    chk("ar_mv_tie", mreq_valid, 1); chk("ar_tie_i", mreq_addr, 64'h6000);

    // randomized traffic against the transaction model
    drive_idle();
    resetn = 0;
    tick();
    resetn = 1;
    pend.delete();
    lat = '{0, '0, '0, '0, '0, 0};
    last_d = 1; m_err = 0;
    for (int c = 0; c < 3000; c++) begin
      ireq_valid = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) ireq_addr = {$urandom, $urandom};
      dreq_valid = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) begin
        dreq_addr = {$urandom, $urandom};
        dreq_size = 3'($urandom_range(0, 3));
        dreq_strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        dreq_data = {$urandom, $urandom};
      end
      mresp_ok = $urandom_range(0, 3) == 0;
      mresp_data = {$urandom, $urandom};
      #1;
      e_mv = 0; e_iok = 0; e_dok = 0; e_id = '0; e_dd = '0; done = 0; to = 0;
      if (pend.size() != 0) begin
        t = pend[0];
        e_mv = 1;
        to = (t.age == TMO - 1) && !mresp_ok;
        done = mresp_ok || to;
        if (done && !t.is_d && ireq_valid) begin
          e_iok = 1;
          if (mresp_ok) e_id = t.addr[2] ? mresp_data[63:32] : mresp_data[31:0];
        end
        if (done && t.is_d && dreq_valid) begin
          e_dok = 1;
          if (mresp_ok) e_dd = mresp_data;
        end
      end
      chk("rnd_mv", mreq_valid, e_mv);
      chk("rnd_maddr", mreq_addr, lat.addr);
      chk("rnd_msize", mreq_size, lat.size);
      chk("rnd_mstb", mreq_strobe, lat.stb);
      chk("rnd_mdata", mreq_data, lat.data);
      chk("rnd_iok", iresp_data_ok, e_iok);
      chk("rnd_idata", iresp_data, e_id);
      chk("rnd_dok", dresp_data_ok, e_dok);
      chk("rnd_ddata", dresp_data, e_dd);
      chk("rnd_err", timeout_err, m_err);
      if (pend.size() != 0) begin
        if (done) begin
          void'(pend.pop_front());
          if (to) m_err = 1;
        end else begin
          pend[0].age++;
        end
      end else if (ireq_valid || dreq_valid) begin
        pick_d = dreq_valid && (!ireq_valid || !last_d);
        if (pick_d) lat = '{1, dreq_addr, dreq_size, dreq_strobe, dreq_data, 0};
        else        lat = '{0, ireq_addr, 3'd2, 8'h00, 64'h0, 0};
        pend.push_back(lat);
        last_d = pick_d;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
